// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: command bytes, default address, frame builder and
// the state encoding of the command-queue output FSM.
package ir_pkg;

  localparam logic [7:0]  NEC_RIGHT        = 8'h62;
  localparam logic [7:0]  NEC_UP           = 8'h60;
  localparam logic [7:0]  NEC_DOWN         = 8'h61;
  localparam logic [7:0]  NEC_LEFT         = 8'h65;
  localparam logic [15:0] NEC_ADDR_DEFAULT = 16'h0707;

  // Output FSM states of the command queue.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } ir_state_e;

  // NEC frame as sent LSB-first by the encoder: address, command, inverted command.
  function automatic logic [31:0] nec_frame(input logic [15:0] addr16,
                                            input logic [7:0]  cmd8);
    return {~cmd8, cmd8, addr16};
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Synchronous show-ahead byte FIFO. dout always shows the oldest entry so the
// reader can consume it in the same cycle it asserts pop. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module ir_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  w_level;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign level     = w_level;
  assign full      = (w_level == (AW+1)'(DEPTH));
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ir_cmd_queue.sv
// Key-press command queue in front of the NEC IR encoder.
// Press pulses set per-key pending bits (repeats merge and flag coalesced),
// a lowest-index-first arbiter moves pending keys into a byte FIFO, and an
// output FSM offers one frame at a time with a minimum gap after each transfer.
//
// Handshake: valid rises only with a fully built cmd and both stay stable
// until a rising edge with valid && ready; that edge is the transfer, and
// valid drops for at least GAP_CYCLES cycles afterwards.
module ir_cmd_queue
  import ir_pkg::*;
#(
  parameter  logic [15:0] ADDR       = NEC_ADDR_DEFAULT,
  parameter  logic [7:0]  CMD_K0     = NEC_RIGHT,
  parameter  logic [7:0]  CMD_K1     = NEC_UP,
  parameter  logic [7:0]  CMD_K2     = NEC_DOWN,
  parameter  logic [7:0]  CMD_K3     = NEC_LEFT,
  parameter  int          DEPTH      = 4,
  parameter  int          GAP_CYCLES = 1000000,
  localparam int          LW         = $clog2(DEPTH) + 1
) (
  input  logic            clk25,
  input  logic            rst,
  input  logic [3:0]      key_pressed,
  output logic [31:0]     cmd,
  output logic            valid,
  input  logic            ready,
  output logic [LW-1:0]   level,
  output logic            coalesced,
  output ir_state_e       dbg_state
);

  localparam int             CW       = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [3:0]    r_pending;
  logic          r_coalesced;
  logic [3:0]    w_clr;
  logic [7:0]    w_push_byte;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [LW-1:0] w_fifo_level;

  ir_state_e     r_state;
  ir_state_e     w_state_next;
  logic [CW-1:0] r_gap_cnt;
  logic [31:0]   r_cmd;

  // Arbiter: lowest-index pending key wins a FIFO slot whenever one is free.
  always_comb begin
    w_clr       = 4'b0000;
    w_push_byte = 8'h00;
    if (!w_fifo_full) begin
      if (r_pending[0]) begin
        w_clr       = 4'b0001;
        w_push_byte = CMD_K0;
      end else if (r_pending[1]) begin
        w_clr       = 4'b0010;
        w_push_byte = CMD_K1;
      end else if (r_pending[2]) begin
        w_clr       = 4'b0100;
        w_push_byte = CMD_K2;
      end else if (r_pending[3]) begin
        w_clr       = 4'b1000;
        w_push_byte = CMD_K3;
      end
    end
  end

  assign w_push = |w_clr;

  // Pending capture: a new press beats the arbiter's clear on the same bit;
  // a press onto a bit that stays pending is merged and reported.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_pending   <= 4'b0000;
      r_coalesced <= 1'b0;
    end else begin
      r_pending   <= (r_pending & ~w_clr) | key_pressed;
      r_coalesced <= |(key_pressed & r_pending & ~w_clr);
    end
  end

  ir_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk25),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_byte),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (w_fifo_level)
  );

  // Output FSM next-state: pop in IDLE, wait for the transfer, then sit out the gap.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (ready) w_state_next = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state, gap counter and frame register; cmd keeps its last frame through the gap.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_cmd     <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_OFFER && ready) begin
        r_gap_cnt <= '0;
      end else if (r_state == ST_GAP && r_gap_cnt != GAP_LAST) begin
        r_gap_cnt <= r_gap_cnt + CW'(1);
      end
      if (w_pop) r_cmd <= nec_frame(ADDR, w_fifo_dout);
    end
  end

  assign cmd       = r_cmd;
  assign valid     = (r_state == ST_OFFER);
  assign level     = w_fifo_level;
  assign coalesced = r_coalesced;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ir_cmd_queue.sv
// Self-checking bench for ir_cmd_queue (DEPTH=4, GAP_CYCLES=16).
// A queue-based reference model predicts valid/cmd/level/coalesced every cycle;
// directed scenarios also compare emitted frames against literal NEC values.
module tb_ir_cmd_queue;
  import ir_pkg::*;

  localparam int DEPTH = 4;
  localparam int G     = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk25 = 1'b0;
  logic          rst;
  logic [3:0]    key_pressed;
  logic [31:0]   cmd;
  logic          valid;
  logic          ready;
  logic [LW-1:0] level;
  logic          coalesced;
  ir_state_e     dbg_state;

  ir_cmd_queue #(.DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
    .clk25       (clk25),
    .rst         (rst),
    .key_pressed (key_pressed),
    .cmd         (cmd),
    .valid       (valid),
    .ready       (ready),
    .level       (level),
    .coalesced   (coalesced),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #20 clk25 = ~clk25;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  m_pend;
  logic [7:0]  m_fifo[$];
  bit          m_offer;
  logic [31:0] m_cmd;
  bit          m_coal;
  longint      edge_n = 0;
  longint      m_idle_from;

  logic [31:0] dut_got[$];   // frames the DUT actually transferred
  longint      hs_edge[$];   // edge number of each transfer
  int          coal_seen;

  function automatic logic [7:0] key_byte(input int i);
    case (i)
      0:       return 8'h62;
      1:       return 8'h60;
      2:       return 8'h61;
      default: return 8'h65;
    endcase
  endfunction

  task automatic model_reset();
    m_pend      = 4'b0000;
    m_fifo.delete();
    m_offer     = 1'b0;
    m_cmd       = 32'h0;
    m_coal      = 1'b0;
    m_idle_from = 0;
  endtask

  // One clock edge of the abstract queue: keys become pending, the lowest pending
  // key moves into a bounded queue, the head is offered when the output is free,
  // and a transfer blocks the next offer until G+1 edges later.
  task automatic model_edge();
    logic [3:0] p;
    logic [3:0] clr;
    logic [7:0] b;
    int         s;
    p   = m_pend;
    s   = m_fifo.size();
    clr = 4'b0000;
    b   = 8'h00;
    if (s < DEPTH && p != 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (p[i]) begin
          clr = 4'b0000;
          clr[i] = 1'b1;
          b = key_byte(i);
        end
      end
    end
    if (!m_offer) begin
      if (edge_n >= m_idle_from && s > 0) begin
        logic [7:0] h;
        h       = m_fifo.pop_front();
        m_cmd   = {~h, h, 16'h0707};
        m_offer = 1'b1;
      end
    end else if (ready) begin
      m_offer     = 1'b0;
      m_idle_from = edge_n + G + 1;
    end
    if (clr != 0) m_fifo.push_back(b);
    m_coal = |(key_pressed & p & ~clr);
    m_pend = (p & ~clr) | key_pressed;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    if (valid === 1'b1 && ready === 1'b1) begin
      dut_got.push_back(cmd);
      hs_edge.push_back(edge_n);
    end
    @(posedge clk25);
    if (!rst) model_edge();
    edge_n++;
    @(negedge clk25);
    check_val("valid", valid, m_offer);
    check_val("cmd", cmd, m_cmd);
    check_val("level", level, m_fifo.size());
    check_val("coalesced", coalesced, m_coal);
    if (coalesced === 1'b1) coal_seen++;
  endtask

  task automatic cyc(input logic [3:0] k, input logic r);
    key_pressed = k;
    ready       = r;
    step();
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(4'b0000, r);
  endtask

  // Wait (bounded) until the DUT has transferred 'want' frames with ready held high.
  task automatic drain_until(input int want, input int budget, input string tag);
    int n;
    n = 0;
    while (dut_got.size() < want && n < budget) begin
      cyc(4'b0000, 1'b1);
      n++;
    end
    check_val(tag, dut_got.size(), want);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #5;
    rst = 1'b1;
    #1;
    check_val({tag, "_valid"}, valid, 1'b0);
    check_val({tag, "_cmd"}, cmd, 32'h0);
    check_val({tag, "_level"}, level, 0);
    model_reset();
    key_pressed = 4'b0000;
    ready       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  logic [31:0] exp_q[$];
  int lat, hi, base;

  initial begin
    rst         = 1'b1;
    key_pressed = 4'b0000;
    ready       = 1'b0;
    model_reset();
    step();
    step();
    check_val("reset_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    idle(3, 1'b1);

    // Single press with ready high: 3-edge latency, then a quiet gap.
    dut_got.delete();
    cyc(4'b0001, 1'b1);
    lat = 1;
    while (valid !== 1'b1 && lat < 10) begin
      cyc(4'b0000, 1'b1);
      lat++;
    end
    check_val("t1_latency", lat, 3);
    check_val("t1_cmd", cmd, 32'h9D620707);
    cyc(4'b0000, 1'b1);
    check_val("t1_xfer", dut_got.size(), 1);
    hi = 0;
    repeat (G + 5) begin
      cyc(4'b0000, 1'b1);
      if (valid === 1'b1) hi++;
    end
    check_val("t1_gap_quiet", hi, 0);

    // All four keys at once: arbitration order and minimum spacing.
    dut_got.delete();
    hs_edge.delete();
    cyc(4'b1111, 1'b1);
    drain_until(4, 4 * (G + 2) + 20, "t2_count");
    exp_q = '{32'h9D620707, 32'h9F600707, 32'h9E610707, 32'h9A650707};
    for (int i = 0; i < 4 && i < dut_got.size(); i++)
      check_val($sformatf("t2_frame%0d", i), dut_got[i], exp_q[i]);
    for (int i = 1; i < hs_edge.size(); i++)
      check_val($sformatf("t2_spacing%0d", i), (hs_edge[i] - hs_edge[i-1]) >= G + 2, 1'b1);
    idle(G + 4, 1'b1);

    // Backpressure: frame held while ready is low, one pulse gives one transfer.
    dut_got.delete();
    cyc(4'b1000, 1'b0);
    idle(40, 1'b0);
    check_val("t3_hold_valid", valid, 1'b1);
    check_val("t3_hold_cmd", cmd, 32'h9A650707);
    cyc(4'b0000, 1'b1);
    idle(G + 5, 1'b0);
    check_val("t3_one_xfer", dut_got.size(), 1);

    // Overload plus coalescing with the FIFO full.
    dut_got.delete();
    coal_seen = 0;
    cyc(4'b0001, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0010, 1'b0);
    idle(6, 1'b0);
    check_val("t4_level_sat", level, 4);
    cyc(4'b0100, 1'b0);
    idle(4, 1'b0);
    cyc(4'b0100, 1'b0);
    idle(3, 1'b0);
    check_val("t4_coalesced_once", coal_seen, 1);
    drain_until(7, 7 * (G + 2) + 50, "t4_count");
    exp_q = '{32'h9D620707, 32'h9F600707, 32'h9E610707, 32'h9A650707,
              32'h9D620707, 32'h9F600707, 32'h9E610707};
    for (int i = 0; i < 7 && i < dut_got.size(); i++)
      check_val($sformatf("t4_frame%0d", i), dut_got[i], exp_q[i]);
    idle(G + 10, 1'b1);
    check_val("t4_no_extra", dut_got.size(), 7);

    // Randomized presses and backpressure against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] k;
      logic       r;
      k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      r = ($urandom_range(0, 3) != 0);
      cyc(k, r);
    end
    idle(6 * (G + 2), 1'b1);

    // Reset while offering.
    cyc(4'b0001, 1'b0);
    idle(4, 1'b0);
    check_val("t5_offer_before", valid, 1'b1);
    do_reset("t5_rst_offer");
    hi = 0;
    repeat (100) begin
      cyc(4'b0000, 1'b1);
      if (valid === 1'b1) hi++;
    end
    check_val("t5_quiet_after_offer_rst", hi, 0);

    // Reset during the gap with another frame still queued.
    base = 0;
    cyc(4'b0011, 1'b1);
    idle(5, 1'b1);
    check_val("t6_in_gap", dbg_state, ST_GAP);
    do_reset("t6_rst_gap");
    hi = 0;
    repeat (100) begin
      cyc(4'b0000, 1'b1);
      if (valid === 1'b1) hi++;
    end
    check_val("t6_quiet_after_gap_rst", hi + base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
